nvm_port_arbiter: RTL

Arbitrates the single NVM array command port between the host access path and the garbage-collection move engine. Each grant covers one complete read/write/erase transaction. Host traffic normally has priority. GC gains absolute priority while `gc_urgent` is high, which is driven from the GC controller's interrupt when only one clean block remains. A starvation counter also guarantees GC forward progress under sustained host load.

---
 rtl/nvm_port_arbiter_if.sv | 47 ++++
 rtl/nvm_port_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/nvm_port_arbiter_if.sv
// Bundle of host, GC and NVM command-port signals around nvm_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface nvm_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              host_req;
  logic [1:0]        host_cmd;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  logic              gc_req;
  logic [1:0]        gc_cmd;
  logic [ADDR_W-1:0] gc_addr;
  logic [DATA_W-1:0] gc_wdata;
  logic              gc_ack;
  logic [DATA_W-1:0] gc_rdata;
  logic              gc_urgent;

  logic              nvm_req;
  logic [1:0]        nvm_cmd;
  logic [ADDR_W-1:0] nvm_addr;
  logic [DATA_W-1:0] nvm_wdata;
  logic              nvm_ready;
  logic [DATA_W-1:0] nvm_rdata;

  logic [1:0]        owner;
  logic              cmd_err;

  modport slave (
    input  host_req, host_cmd, host_addr, host_wdata,
    input  gc_req, gc_cmd, gc_addr, gc_wdata, gc_urgent,
    input  nvm_ready, nvm_rdata,
    output host_ack, host_rdata, gc_ack, gc_rdata,
    output nvm_req, nvm_cmd, nvm_addr, nvm_wdata, owner, cmd_err
  );

  modport master (
    output host_req, host_cmd, host_addr, host_wdata,
    output gc_req, gc_cmd, gc_addr, gc_wdata, gc_urgent,
    output nvm_ready, nvm_rdata,
    input  host_ack, host_rdata, gc_ack, gc_rdata,
    input  nvm_req, nvm_cmd, nvm_addr, nvm_wdata, owner, cmd_err
  );
endinterface

// File: rtl/nvm_port_arbiter.sv
// Arbitrates the NVM command port between host and GC, one transaction per grant.
// Define GC_STARVE_EN to add the starvation counter that forces GC after STARVE_LIMIT host grants.
module nvm_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  nvm_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, HOST_BUSY, GC_BUSY, ERR_ACK} state_e;

  localparam logic [1:0] CMD_RSVD  = 2'b11;
  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_HOST  = 2'b01;
  localparam logic [1:0] OWN_GC    = 2'b10;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("nvm_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  state_e            state_q, state_d;
  logic              err_gc_q, err_gc_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              grant_host, grant_gc, starve_hit;
  logic [1:0]        win_cmd;
  logic              host_done, gc_done, in_err;

`ifdef GC_STARVE_EN
  logic [3:0] starve_q, starve_d;

  assign starve_hit = (starve_q == LIMIT);

  always_comb begin
    starve_d = starve_q;
    if (grant_gc) begin
      starve_d = '0;
    end else if (grant_host && bus.gc_req) begin
      if (starve_q != LIMIT) starve_d = starve_q + 4'd1;
    end else if (state_q == IDLE && !bus.gc_req) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign starve_hit = 1'b0;
`endif

  // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    err_gc_d   = err_gc_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    grant_host = 1'b0;
    grant_gc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.gc_req && (bus.gc_urgent || starve_hit)) grant_gc   = 1'b1;
        else if (bus.host_req)                           grant_host = 1'b1;
        else if (bus.gc_req)                             grant_gc   = 1'b1;
      end
      HOST_BUSY, GC_BUSY: if (bus.nvm_ready) state_d = IDLE;
      default:            state_d = IDLE;
    endcase

    win_cmd = grant_gc ? bus.gc_cmd : bus.host_cmd;

    // A reserved command is acknowledged as an error without disturbing the NVM-side registers.
    if (grant_host || grant_gc) begin
      err_gc_d = grant_gc;
      if (win_cmd == CMD_RSVD) begin
        state_d = ERR_ACK;
      end else begin
        state_d = grant_gc ? GC_BUSY : HOST_BUSY;
        cmd_d   = win_cmd;
        addr_d  = grant_gc ? bus.gc_addr  : bus.host_addr;
        wdata_d = grant_gc ? bus.gc_wdata : bus.host_wdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      err_gc_q <= 1'b0;
      cmd_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      err_gc_q <= err_gc_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Acks and rdata are combinational so completion is visible in the nvm_ready cycle.
  always_comb begin
    host_done = (state_q == HOST_BUSY) && bus.nvm_ready;
    gc_done   = (state_q == GC_BUSY)   && bus.nvm_ready;
    in_err    = (state_q == ERR_ACK);

    bus.nvm_req    = (state_q == HOST_BUSY) || (state_q == GC_BUSY);
    bus.nvm_cmd    = cmd_q;
    bus.nvm_addr   = addr_q;
    bus.nvm_wdata  = wdata_q;
    bus.cmd_err    = in_err;
    bus.host_ack   = host_done || (in_err && !err_gc_q);
    bus.gc_ack     = gc_done   || (in_err &&  err_gc_q);
    bus.host_rdata = host_done ? bus.nvm_rdata : '0;
    bus.gc_rdata   = gc_done   ? bus.nvm_rdata : '0;

    case (state_q)
      HOST_BUSY: bus.owner = OWN_HOST;
      GC_BUSY:   bus.owner = OWN_GC;
      ERR_ACK:   bus.owner = err_gc_q ? OWN_GC : OWN_HOST;
      default:   bus.owner = OWN_NONE;
    endcase
  end

endmodule
